// File: rtl/aes_pkg.sv
// Shared definitions for the SPI-to-AES command controller: opcodes, key-size
// codes, FSM states and sticky error bit positions.
package aes_pkg;

    localparam logic [1:0] OP_KEY   = 2'b00;
    localparam logic [1:0] OP_ENC   = 2'b01;
    localparam logic [1:0] OP_DEC   = 2'b10;
    localparam logic [1:0] OP_FLUSH = 2'b11;

    localparam logic [1:0] KSZ_128 = 2'b00;
    localparam logic [1:0] KSZ_192 = 2'b01;
    localparam logic [1:0] KSZ_256 = 2'b10;
    localparam logic [1:0] KSZ_BAD = 2'b11;

    localparam int ERR_NOKEY = 0;
    localparam int ERR_OVF   = 1;
    localparam int ERR_KEY   = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    // Key words per key-size code; rounds are always nk + 6.
    function automatic logic [3:0] ksz_nk(input logic [1:0] ksz);
        case (ksz)
            KSZ_128: ksz_nk = 4'd4;
            KSZ_192: ksz_nk = 4'd6;
            default: ksz_nk = 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/aes_blk_fifo.sv
// Circular pending-block queue; pointers carry one extra wrap bit so that
// full and empty are told apart by the MSB alone.
module aes_blk_fifo #(
    parameter int W     = 129,
    parameter int DEPTH = 4
) (
    input  logic         sclk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         clear,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wptr;
    logic [AW:0]  rptr;
    logic         do_push;
    logic         do_pop;

    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign empty   = (wptr == rptr);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr[AW-1:0]];

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else if (clear) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    // NOTE: storage is not reset; the pointers alone define which entries are meaningful.
    always_ff @(posedge sclk) begin
        if (do_push && !clear) mem[wptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/aes_spi_cmd_ctrl.sv
// Opcode-driven command controller between an SPI frame interface and an AES
// core: key loading, encrypt/decrypt block queue, and a held result buffer.
module aes_spi_cmd_ctrl
    import aes_pkg::*;
#(
    parameter int BLK_W   = 128,
    parameter int KEY_W   = 256,
    parameter int QDEPTH  = 4,
    parameter int FRAME_W = KEY_W + 4
) (
    input  logic               sclk,
    input  logic               rst_n,
    input  logic [FRAME_W-1:0] rx_frame,
    input  logic               rx_done,
    output logic [3:0]         nk,
    output logic [3:0]         nr,
    output logic [KEY_W-1:0]   key,
    output logic               core_start,
    output logic               core_mode,
    output logic [BLK_W-1:0]   core_in,
    input  logic               core_done,
    input  logic [BLK_W-1:0]   core_out,
    output logic [BLK_W-1:0]   tx_data,
    output logic               tx_valid,
    input  logic               tx_ack,
    output logic               key_ok,
    output logic [2:0]         err
);

    logic [1:0]         opcode;
    logic [1:0]         ksz;
    logic [FRAME_W-5:0] payload;

    state_t             state;
    state_t             state_next;

    logic               key_cmd;
    logic               key_load;
    logic               blk_cmd;
    logic               push;
    logic               pop;
    logic               flush;
    logic [2:0]         err_set;

    logic [BLK_W:0]     fifo_wdata;
    logic [BLK_W:0]     fifo_rdata;
    logic               fifo_full;
    logic               fifo_empty;

    assign opcode  = rx_frame[FRAME_W-1 -: 2];
    assign ksz     = rx_frame[FRAME_W-3 -: 2];
    assign payload = rx_frame[FRAME_W-5:0];

    // Frame decode; nothing here acts outside an rx_done cycle.
    always_comb begin
        key_cmd  = rx_done && (opcode == OP_KEY);
        blk_cmd  = rx_done && ((opcode == OP_ENC) || (opcode == OP_DEC));
        flush    = rx_done && (opcode == OP_FLUSH);
        key_load = key_cmd && (ksz != KSZ_BAD) && fifo_empty && (state == ST_IDLE);
        push     = blk_cmd && key_ok && !fifo_full;

        err_set            = '0;
        err_set[ERR_NOKEY] = blk_cmd && !key_ok;
        err_set[ERR_OVF]   = blk_cmd && key_ok && fifo_full;
        err_set[ERR_KEY]   = key_cmd && !key_load;

        fifo_wdata = {(opcode == OP_DEC), payload[BLK_W-1:0]};
    end

    // A flush in the same cycle wins over the head pop, so a flushed block never starts.
    assign pop = (state == ST_IDLE) && !fifo_empty && !tx_valid && !flush;

    aes_blk_fifo #(
        .W     (BLK_W + 1),
        .DEPTH (QDEPTH)
    ) u_fifo (
        .sclk  (sclk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .clear (flush),
        .wdata (fifo_wdata),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        state_next = state;
        core_start = 1'b0;
        case (state)
            ST_IDLE:  if (pop) state_next = ST_START;
            ST_START: begin
                core_start = 1'b1;
                state_next = ST_WAIT;
            end
            ST_WAIT:  if (core_done) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            nk        <= '0;
            nr        <= '0;
            key       <= '0;
            key_ok    <= 1'b0;
            err       <= '0;
            core_mode <= 1'b0;
            core_in   <= '0;
            tx_data   <= '0;
            tx_valid  <= 1'b0;
        end else begin
            if (key_load) begin
                nk     <= ksz_nk(ksz);
                nr     <= ksz_nk(ksz) + 4'd6;
                key    <= payload[KEY_W-1:0];
                key_ok <= 1'b1;
            end

            if (flush) err <= '0;
            else       err <= err | err_set;

            if (pop) begin
                core_in   <= fifo_rdata[BLK_W-1:0];
                core_mode <= fifo_rdata[BLK_W];
            end

            // The result slot is empty whenever a block is in flight, so done and ack never meet.
            if ((state == ST_WAIT) && core_done) begin
                tx_data  <= core_out;
                tx_valid <= 1'b1;
            end else if (tx_ack) begin
                tx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_aes_spi_cmd_ctrl.sv
// Directed self-checking bench for aes_spi_cmd_ctrl with a fixed-latency
// behavioural cipher core driving core_done/core_out.
module tb_aes_spi_cmd_ctrl;

    localparam int BLK_W    = 128;
    localparam int KEY_W    = 256;
    localparam int FRAME_W  = KEY_W + 4;
    localparam int CORE_LAT = 12;

    localparam logic [127:0] KNOWN_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] KNOWN_PT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] ENC_MASK = 128'h5a5a5a5a_5a5a5a5a_5a5a5a5a_5a5a5a5a;
    localparam logic [127:0] DEC_MASK = 128'hc3c3c3c3_c3c3c3c3_c3c3c3c3_c3c3c3c3;
    localparam logic [255:0] KEY1     = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] KEY2     = {128'hffeeddccbbaa99887766554433221100, 128'h1234};

    logic               sclk;
    logic               rst_n;
    logic [FRAME_W-1:0] rx_frame;
    logic               rx_done;
    logic [3:0]         nk;
    logic [3:0]         nr;
    logic [KEY_W-1:0]   key;
    logic               core_start;
    logic               core_mode;
    logic [BLK_W-1:0]   core_in;
    logic               core_done;
    logic [BLK_W-1:0]   core_out;
    logic [BLK_W-1:0]   tx_data;
    logic               tx_valid;
    logic               tx_ack;
    logic               key_ok;
    logic [2:0]         err;

    int checks   = 0;
    int failures = 0;

    aes_spi_cmd_ctrl #(
        .BLK_W   (BLK_W),
        .KEY_W   (KEY_W),
        .QDEPTH  (4),
        .FRAME_W (FRAME_W)
    ) dut (
        .sclk       (sclk),
        .rst_n      (rst_n),
        .rx_frame   (rx_frame),
        .rx_done    (rx_done),
        .nk         (nk),
        .nr         (nr),
        .key        (key),
        .core_start (core_start),
        .core_mode  (core_mode),
        .core_in    (core_in),
        .core_done  (core_done),
        .core_out   (core_out),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ack     (tx_ack),
        .key_ok     (key_ok),
        .err        (err)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    function automatic logic [127:0] cipher(input logic [127:0] din, input logic mode);
        if (mode && (din == KNOWN_CT)) return KNOWN_PT;
        return din ^ (mode ? DEC_MASK : ENC_MASK);
    endfunction

    // Behavioural core: answers every start pulse CORE_LAT cycles later.
    initial begin : core_model
        logic [127:0] m_in;
        logic         m_mode;
        core_done = 1'b0;
        core_out  = '0;
        forever begin
            @(negedge sclk);
            if (core_start === 1'b1) begin
                m_in   = core_in;
                m_mode = core_mode;
                repeat (CORE_LAT) @(negedge sclk);
                core_out  = cipher(m_in, m_mode);
                core_done = 1'b1;
                @(negedge sclk);
                core_done = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [259:0] obs, input logic [259:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [1:0] op, input logic [1:0] ksz, input logic [255:0] pl);
        @(negedge sclk);
        rx_frame = {op, ksz, pl};
        rx_done  = 1'b1;
        @(negedge sclk);
        rx_done  = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (tx_valid !== 1'b1 && n < 100) begin
            @(negedge sclk);
            n++;
        end
        check(tag, tx_valid, 1'b1);
    endtask

    task automatic ack(input string tag);
        @(negedge sclk);
        tx_ack = 1'b1;
        @(negedge sclk);
        tx_ack = 1'b0;
        check(tag, tx_valid, 1'b0);
    endtask

    initial begin : stimulus
        logic         saw_start;
        logic         saw_valid;
        logic [127:0] blk [6];

        rst_n    = 1'b0;
        rx_frame = '0;
        rx_done  = 1'b0;
        tx_ack   = 1'b0;
        repeat (3) @(negedge sclk);
        check("reset_ctrl", {nk, nr, key_ok, err, core_start, core_mode, tx_valid}, '0);
        check("reset_key", key, '0);
        check("reset_data", {core_in, tx_data}, '0);
        rst_n = 1'b1;

        // Block with no key loaded is dropped and flagged.
        send(2'b01, 2'b00, 256'h1111);
        saw_start = 1'b0;
        repeat (6) begin
            @(negedge sclk);
            saw_start |= core_start;
        end
        check("nokey_start", saw_start, 1'b0);
        check("nokey_err", err, 3'b001);
        send(2'b11, 2'b00, '0);
        check("flush_err", err, 3'b000);

        send(2'b00, 2'b00, KEY1);
        check("key1_nk", nk, 4'd4);
        check("key1_nr", nr, 4'd10);
        check("key1_key", key, KEY1);
        check("key1_ok_err", {key_ok, err}, 4'b1000);

        // Decrypt of the reference vector; start must come two cycles after rx_done.
        send(2'b10, 2'b00, {128'h0, KNOWN_CT});
        check("dec_start_early", core_start, 1'b0);
        @(negedge sclk);
        check("dec_start", core_start, 1'b1);
        check("dec_mode", core_mode, 1'b1);
        check("dec_in", core_in, KNOWN_CT);
        wait_valid("dec_valid");
        check("dec_data", tx_data, KNOWN_PT);
        repeat (3) @(negedge sclk);
        check("dec_hold", tx_valid, 1'b1);
        ack("dec_ack");

        // Six back-to-back encrypts: one in flight, four queued, sixth dropped.
        for (int i = 0; i < 6; i++) blk[i] = 128'ha0a1a2a3_00000000_00000000_00000000 + 128'(i);
        for (int i = 0; i < 6; i++) begin
            @(negedge sclk);
            rx_frame = {2'b01, 2'b00, 128'h0, blk[i]};
            rx_done  = 1'b1;
        end
        @(negedge sclk);
        rx_done = 1'b0;
        check("ovf_err", err, 3'b010);
        check("ovf_mode", core_mode, 1'b0);
        check("ovf_in0", core_in, blk[0]);
        for (int i = 0; i < 5; i++) begin
            wait_valid($sformatf("ovf_valid%0d", i));
            check($sformatf("ovf_data%0d", i), tx_data, blk[i] ^ ENC_MASK);
            ack($sformatf("ovf_ack%0d", i));
        end
        saw_valid = 1'b0;
        repeat (30) begin
            @(negedge sclk);
            saw_valid |= tx_valid;
        end
        check("ovf_sixth_dropped", saw_valid, 1'b0);

        // Illegal key loads leave the key intact.
        send(2'b11, 2'b00, '0);
        check("flush2_err", err, 3'b000);
        send(2'b00, 2'b11, KEY2);
        check("badksz_err", err, 3'b100);
        check("badksz_nknr", {nk, nr}, {4'd4, 4'd10});
        check("badksz_key", key, KEY1);
        send(2'b01, 2'b00, {128'h0, KNOWN_PT});
        @(negedge sclk);
        check("busy_start", core_start, 1'b1);
        send(2'b00, 2'b10, KEY2);
        check("busy_key_err", err, 3'b100);
        check("busy_key_nknr", {nk, nr}, {4'd4, 4'd10});
        check("busy_key_key", key, KEY1);
        send(2'b11, 2'b00, '0);
        check("busy_flush_err", err, 3'b000);
        wait_valid("busy_flush_valid");
        check("busy_flush_data", tx_data, KNOWN_PT ^ ENC_MASK);
        ack("busy_flush_ack");

        // Reset in WAIT; the late core_done from the model must be ignored.
        send(2'b01, 2'b00, {128'h0, blk[2]});
        @(negedge sclk);
        check("rst_start", core_start, 1'b1);
        repeat (3) @(negedge sclk);
        rst_n = 1'b0;
        #1;
        check("rst_async_ctrl", {nk, nr, key_ok, err, core_start, core_mode, tx_valid}, '0);
        check("rst_async_data", {core_in, tx_data}, '0);
        check("rst_async_key", key, '0);
        repeat (2) @(negedge sclk);
        rst_n = 1'b1;
        saw_valid = 1'b0;
        saw_start = 1'b0;
        repeat (25) begin
            @(negedge sclk);
            saw_valid |= tx_valid;
            saw_start |= core_start;
        end
        check("rst_stray_done", {saw_valid, saw_start}, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
